// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way bus arbiter.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // OR-reduces set-bit positions, so no priority chain is built for a one-hot input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of REQ & MASK scanning PTR, PTR+1, ... (mod 8).
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [IDX_W-1:0]   PTR,
  input  logic [NUM_REQ-1:0] MASK,
  output logic               HIT,
  output logic [IDX_W-1:0]   IDX
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] rot;

  assign cand = REQ & MASK;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    rot = NUM_REQ'({cand, cand} >> PTR);
    HIT = 1'b0;
    IDX = '0;
    // Scan from the far end so the lowest rotated offset is the last (winning) assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        HIT = 1'b1;
        IDX = PTR + IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin owner arbiter for the 8-source internal bus; registered one-hot grant and mux select.
// Optional owner hold timeout is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic [IDX_W-1:0]   SEL,
  output logic               BUS_VALID,
  output logic               TO_PULSE
);

  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("bus_arbiter8: CNT_W too narrow to hold MAX_HOLD");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [IDX_W-1:0]   sel_q,   sel_d;

  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   next_ptr;
  logic               req_own;
  logic               others_req;
  logic               timeout;
  logic               grant_new;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;

  assign owner      = onehot_to_idx(gnt_q);
  assign next_ptr   = owner + IDX_W'(1);
  assign req_own    = |(REQ & gnt_q);
  assign others_req = |(REQ & ~gnt_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q,  to_d;

  // >= also covers a counter already saturated when a second requester shows up late.
  assign timeout  = (state_q == BUSY) && req_own && others_req && (cnt_q >= HOLD_LAST);
  assign TO_PULSE = to_q;
`else
  assign timeout  = 1'b0;
  assign TO_PULSE = 1'b0;
`endif

  rr_pick8 u_pick (
    .REQ  (REQ),
    .PTR  (pick_ptr),
    .MASK (pick_mask),
    .HIT  (pick_hit),
    .IDX  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    pick_ptr  = ptr_q;
    pick_mask = '1;
    grant_new = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_new = 1'b1;
          state_d   = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      BUSY: begin
        pick_ptr = next_ptr;
        if (timeout) begin
          pick_mask = ~gnt_q;
          ptr_d     = next_ptr;
          grant_new = 1'b1;
`ifdef ARB_TIMEOUT_EN
          to_d      = 1'b1;
          cnt_d     = '0;
`endif
        end else if (req_own) begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q != HOLD_SAT) cnt_d = cnt_q + CNT_W'(1);
`endif
        end else if (pick_hit) begin
          // Zero-bubble handoff: owner released while someone else is waiting.
          ptr_d     = next_ptr;
          grant_new = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_new) begin
      gnt_d = NUM_REQ'(1) << pick_idx;
      sel_d = pick_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign GNT       = gnt_q;
  assign SEL       = sel_q;
  assign BUS_VALID = |gnt_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed self-checking bench for bus_arbiter8; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_bus_arbiter8;
  import arb_pkg::*;

  logic               CLK   = 1'b0;
  logic               RST_N = 1'b0;
  logic [NUM_REQ-1:0] REQ   = '0;
  logic [NUM_REQ-1:0] GNT;
  logic [IDX_W-1:0]   SEL;
  logic               BUS_VALID;
  logic               TO_PULSE;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  bus_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ       (REQ),
    .GNT       (GNT),
    .SEL       (SEL),
    .BUS_VALID (BUS_VALID),
    .TO_PULSE  (TO_PULSE)
  );

  // Advance one clock and land 1 time unit after the edge for sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ   = '0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ   = 8'hFF;
    step();
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID, TO_PULSE} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: gnt=%h sel=%0d bv=%b to=%b, want gnt=00 sel=0 bv=0 to=0",
               GNT, SEL, BUS_VALID, TO_PULSE);
    end
    RST_N = 1'b1;
    REQ   = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if ({GNT, SEL, BUS_VALID} !== {8'h00, 3'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL idle_no_req[%0d]: gnt=%h sel=%0d bv=%b, want gnt=00 sel=0 bv=0",
                 i, GNT, SEL, BUS_VALID);
      end
    end
    REQ = 8'h10;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h10, 3'd4, 1'b1}) begin
      tests_failed++;
      $display("FAIL first_grant: gnt=%h sel=%0d bv=%b, want gnt=10 sel=4 bv=1",
               GNT, SEL, BUS_VALID);
    end
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] exp_gnt;
    logic [IDX_W-1:0]   exp_sel;
    do_reset();
    REQ = 8'hFF;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h01, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL fair_start: gnt=%h sel=%0d bv=%b, want gnt=01 sel=0 bv=1",
               GNT, SEL, BUS_VALID);
    end
    // Each owner in turn drops its bit for one cycle while everyone else keeps requesting.
    for (int k = 0; k < 8; k++) begin
      REQ     = 8'hFF & ~(8'h01 << k);
      exp_sel = IDX_W'((k + 1) % 8);
      exp_gnt = 8'h01 << exp_sel;
      step();
      tests_run++;
      if ({GNT, SEL, BUS_VALID} !== {exp_gnt, exp_sel, 1'b1}) begin
        tests_failed++;
        $display("FAIL fair_rotate[%0d]: gnt=%h sel=%0d bv=%b, want gnt=%h sel=%0d bv=1",
                 k, GNT, SEL, BUS_VALID, exp_gnt, exp_sel);
      end
    end
  endtask

  task automatic test_handoff_idle();
    do_reset();
    REQ = 8'h04;
    step();
    REQ = 8'h24;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h04, 3'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL hold_owner2: gnt=%h sel=%0d bv=%b, want gnt=04 sel=2 bv=1",
               GNT, SEL, BUS_VALID);
    end
    REQ = 8'h20;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h20, 3'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL handoff_2_to_5: gnt=%h sel=%0d bv=%b, want gnt=20 sel=5 bv=1",
               GNT, SEL, BUS_VALID);
    end
    REQ = 8'h00;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h00, 3'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL release_idle: gnt=%h sel=%0d bv=%b, want gnt=00 sel=5 bv=0",
               GNT, SEL, BUS_VALID);
    end
    // Pointer now 6: among {0,5,6} the scan 6,7,0,... must choose 6.
    REQ = 8'h61;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h40, 3'd6, 1'b1}) begin
      tests_failed++;
      $display("FAIL ptr_after_idle: gnt=%h sel=%0d bv=%b, want gnt=40 sel=6 bv=1",
               GNT, SEL, BUS_VALID);
    end
  endtask

  task automatic test_wrap_withdraw();
    logic [NUM_REQ-1:0] req_seq [4];
    req_seq = '{8'h01, 8'h03, 8'h01, 8'h01};
    do_reset();
    REQ = 8'h80;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h80, 3'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL owner7: gnt=%h sel=%0d bv=%b, want gnt=80 sel=7 bv=1",
               GNT, SEL, BUS_VALID);
    end
    REQ = 8'h03;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h01, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_to_0: gnt=%h sel=%0d bv=%b, want gnt=01 sel=0 bv=1",
               GNT, SEL, BUS_VALID);
    end
    // Requester 1 pulses once while 0 holds, then goes away before 0 releases.
    for (int i = 0; i < 4; i++) begin
      REQ = req_seq[i];
      step();
      tests_run++;
      if ({GNT, SEL, BUS_VALID} !== {8'h01, 3'd0, 1'b1}) begin
        tests_failed++;
        $display("FAIL withdraw_hold[%0d]: gnt=%h sel=%0d bv=%b, want gnt=01 sel=0 bv=1",
                 i, GNT, SEL, BUS_VALID);
      end
    end
    REQ = 8'h00;
    step();
    step();
    tests_run++;
    if ({GNT, BUS_VALID} !== {8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL withdraw_never_granted: gnt=%h bv=%b, want gnt=00 bv=0", GNT, BUS_VALID);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    REQ = 8'h04;
    step();
    REQ = 8'h08;
    step();
    REQ = 8'hFF;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h08, 3'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL owner3_before_reset: gnt=%h sel=%0d bv=%b, want gnt=08 sel=3 bv=1",
               GNT, SEL, BUS_VALID);
    end
    RST_N = 1'b0;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID, TO_PULSE} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_grant: gnt=%h sel=%0d bv=%b to=%b, want gnt=00 sel=0 bv=0 to=0",
               GNT, SEL, BUS_VALID, TO_PULSE);
    end
    RST_N = 1'b1;
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID} !== {8'h01, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ptr_cleared_by_reset: gnt=%h sel=%0d bv=%b, want gnt=01 sel=0 bv=1",
               GNT, SEL, BUS_VALID);
    end
  endtask

  task automatic test_hold_timeout();
    do_reset();
    REQ = 8'h03;
    step();
    tests_run++;
    if ({GNT, TO_PULSE} !== {8'h01, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_start: gnt=%h to=%b, want gnt=01 to=0", GNT, TO_PULSE);
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      step();
      tests_run++;
      if ({GNT, TO_PULSE} !== {8'h01, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_before_timeout[%0d]: gnt=%h to=%b, want gnt=01 to=0", i, GNT, TO_PULSE);
      end
    end
    step();
    tests_run++;
    if ({GNT, SEL, BUS_VALID, TO_PULSE} !== {8'h02, 3'd1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL timeout_release: gnt=%h sel=%0d bv=%b to=%b, want gnt=02 sel=1 bv=1 to=1",
               GNT, SEL, BUS_VALID, TO_PULSE);
    end
    step();
    tests_run++;
    if ({GNT, TO_PULSE} !== {8'h02, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_pulse_width: gnt=%h to=%b, want gnt=02 to=0", GNT, TO_PULSE);
    end
    REQ = 8'h01;
    step();
    tests_run++;
    if ({GNT, TO_PULSE} !== {8'h01, 1'b0}) begin
      tests_failed++;
      $display("FAIL sole_requester_grant: gnt=%h to=%b, want gnt=01 to=0", GNT, TO_PULSE);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if ({GNT, TO_PULSE} !== {8'h01, 1'b0}) begin
        tests_failed++;
        $display("FAIL sole_requester_hold[%0d]: gnt=%h to=%b, want gnt=01 to=0", i, GNT, TO_PULSE);
      end
    end
`else
    // Without the timeout the owner keeps the bus however long others wait.
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if ({GNT, SEL, TO_PULSE} !== {8'h01, 3'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_no_timeout[%0d]: gnt=%h sel=%0d to=%b, want gnt=01 sel=0 to=0",
                 i, GNT, SEL, TO_PULSE);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_handoff_idle();
    test_wrap_withdraw();
    test_reset_mid_grant();
    test_hold_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
